// File: rtl/hasti_sram_if.sv
// if_hasti_slave_io: AHB-Lite (HASTI) signal bundle between a crossbar port
// and a slave, with master- and slave-side views.
interface if_hasti_slave_io;
    logic [31:0] haddr;
    logic        hwrite;
    logic [2:0]  hsize;
    logic [2:0]  hburst;
    logic [3:0]  hprot;
    logic [1:0]  htrans;
    logic        hmastlock;
    logic [31:0] hwdata;
    logic [31:0] hrdata;
    logic        hready;
    logic        hresp;

    modport slave (
        input  haddr,
        input  hwrite,
        input  hsize,
        input  hburst,
        input  hprot,
        input  htrans,
        input  hmastlock,
        input  hwdata,
        output hrdata,
        output hready,
        output hresp
    );

    modport master (
        output haddr,
        output hwrite,
        output hsize,
        output hburst,
        output hprot,
        output htrans,
        output hmastlock,
        output hwdata,
        input  hrdata,
        input  hready,
        input  hresp
    );
endinterface

// File: rtl/hasti_sram.sv
// hasti_sram: AHB-Lite slave for a 256Kx16 asynchronous SRAM.
// Each transfer becomes one or two registered half-word SRAM cycles.
module hasti_sram #(
    parameter int SRAM_WAIT = 1
) (
    input  logic             hclk,
    input  logic             hresetn,
    if_hasti_slave_io.slave  bus,
    inout  wire  [15:0]      SRAM_DQ,
    output logic [17:0]      SRAM_ADDR,
    output logic             SRAM_UB_N,
    output logic             SRAM_LB_N,
    output logic             SRAM_CE_N,
    output logic             SRAM_OE_N,
    output logic             SRAM_WE_N
);

    localparam int CW = (SRAM_WAIT > 1) ? $clog2(SRAM_WAIT) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(SRAM_WAIT - 1);

    typedef enum logic [2:0] {
        IDLE,
        RD,
        WR_SETUP,
        WR,
        WR_HOLD,
        RESP
    } state_t;

    state_t          state;
    logic            hready_q;
    logic [31:0]     hrdata_q;
    logic [17:0]     addr_q;
    logic            ub_n_q;
    logic            lb_n_q;
    logic            ce_n_q;
    logic            oe_n_q;
    logic            we_n_q;
    logic            dq_oe_q;
    logic [15:0]     dq_out_q;
    logic [15:0]     lo_q;
    logic [CW-1:0]   cnt;
    logic            word_q;
    logic            hi_q;
    logic            up_q;

    logic            accept;
    logic            a_word;
    logic [17:0]     a_addr;
    logic            a_ub_n;
    logic            a_lb_n;
    logic            unused_bus;

    // Address-phase decode of the transfer currently on the bus
    always_comb begin
        accept = hready_q & bus.htrans[1];
        a_word = bus.hsize[2] | bus.hsize[1];
        a_addr = a_word ? {bus.haddr[18:2], 1'b0}
                        : bus.haddr[18:1];
        a_ub_n = (bus.hsize == 3'd0) & ~bus.haddr[0];
        a_lb_n = (bus.hsize == 3'd0) &  bus.haddr[0];
    end

    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            state    <= IDLE;
            hready_q <= 1'b1;
            hrdata_q <= '0;
            addr_q   <= '0;
            ub_n_q   <= 1'b1;
            lb_n_q   <= 1'b1;
            ce_n_q   <= 1'b1;
            oe_n_q   <= 1'b1;
            we_n_q   <= 1'b1;
            dq_oe_q  <= 1'b0;
            dq_out_q <= '0;
            lo_q     <= '0;
            cnt      <= '0;
            word_q   <= 1'b0;
            hi_q     <= 1'b0;
            up_q     <= 1'b0;
        end else begin
            unique case (state)
                IDLE, RESP: begin
                    if (accept) begin
                        addr_q   <= a_addr;
                        ub_n_q   <= a_ub_n;
                        lb_n_q   <= a_lb_n;
                        ce_n_q   <= 1'b0;
                        hready_q <= 1'b0;
                        cnt      <= '0;
                        word_q   <= a_word;
                        hi_q     <= 1'b0;
                        up_q     <= ~a_word & bus.haddr[1];
                        if (bus.hwrite) begin
                            state <= WR_SETUP;
                        end else begin
                            state  <= RD;
                            oe_n_q <= 1'b0;
                        end
                    end else begin
                        state    <= IDLE;
                        hready_q <= 1'b1;
                        ce_n_q   <= 1'b1;
                        ub_n_q   <= 1'b1;
                        lb_n_q   <= 1'b1;
                    end
                end
                RD: begin
                    cnt <= cnt + 1'b1;
                    if (cnt == CNT_LAST) begin
                        cnt <= '0;
                        if (word_q && !hi_q) begin
                            lo_q   <= SRAM_DQ;
                            hi_q   <= 1'b1;
                            addr_q <= {addr_q[17:1], 1'b1};
                        end else begin
                            hrdata_q <= word_q ? {SRAM_DQ, lo_q}
                                               : {SRAM_DQ, SRAM_DQ};
                            state    <= RESP;
                            hready_q <= 1'b1;
                            oe_n_q   <= 1'b1;
                            ce_n_q   <= 1'b1;
                            ub_n_q   <= 1'b1;
                            lb_n_q   <= 1'b1;
                        end
                    end
                end
                WR_SETUP: begin
                    // Upper bus lane for the high half of a word or an upper sub-word
                    dq_out_q <= (up_q | hi_q) ? bus.hwdata[31:16]
                                              : bus.hwdata[15:0];
                    dq_oe_q  <= 1'b1;
                    we_n_q   <= 1'b0;
                    cnt      <= '0;
                    state    <= WR;
                end
                WR: begin
                    cnt <= cnt + 1'b1;
                    if (cnt == CNT_LAST) begin
                        cnt    <= '0;
                        we_n_q <= 1'b1;
                        state  <= WR_HOLD;
                    end
                end
                WR_HOLD: begin
                    dq_oe_q <= 1'b0;
                    if (word_q && !hi_q) begin
                        hi_q   <= 1'b1;
                        addr_q <= {addr_q[17:1], 1'b1};
                        state  <= WR_SETUP;
                    end else begin
                        state    <= RESP;
                        hready_q <= 1'b1;
                        ce_n_q   <= 1'b1;
                        ub_n_q   <= 1'b1;
                        lb_n_q   <= 1'b1;
                    end
                end
                default: begin
                    state    <= IDLE;
                    hready_q <= 1'b1;
                    ce_n_q   <= 1'b1;
                    oe_n_q   <= 1'b1;
                    we_n_q   <= 1'b1;
                    dq_oe_q  <= 1'b0;
                end
            endcase
        end
    end

    assign SRAM_DQ   = dq_oe_q ? dq_out_q : 16'hzzzz;
    assign SRAM_ADDR = addr_q;
    assign SRAM_UB_N = ub_n_q;
    assign SRAM_LB_N = lb_n_q;
    assign SRAM_CE_N = ce_n_q;
    assign SRAM_OE_N = oe_n_q;
    assign SRAM_WE_N = we_n_q;

    assign bus.hready = hready_q;
    assign bus.hrdata = hrdata_q;
    assign bus.hresp  = 1'b0;

    assign unused_bus = ^{bus.haddr[31:19], bus.htrans[0], bus.hburst,
                          bus.hprot, bus.hmastlock};

endmodule
